// File: rtl/lcd_cmd_issuer_if.sv
// Host-side push bus and LCD-controller command/handshake bundle for lcd_cmd_issuer.
// Master is the host/controller side, slave is the issuer.
interface lcd_cmd_issuer_if #(
  parameter int DEPTH = 8
);
  logic [3:0]              in_cmd;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              cmd;
  logic                    cmd_valid;
  logic                    busy;
  logic                    done;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [7:0]              issued_cnt;
  logic [3:0]              err_cnt;
  logic                    seq_done;

  modport master (
    output in_cmd, in_valid, busy, done,
    input  in_ready, cmd, cmd_valid, fifo_level, issued_cnt, err_cnt, seq_done
  );

  modport slave (
    input  in_cmd, in_valid, busy, done,
    output in_ready, cmd, cmd_valid, fifo_level, issued_cnt, err_cnt, seq_done
  );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// FIFO-buffered LCD command issuer: first issue strobe one cycle after the push, then >=3-cycle spacing.
// Host sees in_ready low when full or once write-out has been issued; the controller throttles via busy in RUN.
module lcd_cmd_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
endmodule

module lcd_cmd_issuer #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  lcd_cmd_issuer_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_RUN,
    ST_ISSUE,
    ST_GUARD,
    ST_WRITE_WAIT,
    ST_FINISHED
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [7:0]             issued_cnt_q, issued_cnt_d;
  logic [3:0]             err_cnt_q, err_cnt_d;
  logic                   seq_done_q, seq_done_d;

  logic                   push;
  logic                   pop;
  logic                   in_ready;
  logic [3:0]             head;
  logic                   head_legal;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   empty;

  lcd_cmd_fifo #(
    .W     (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.in_cmd),
    .pop      (pop),
    .head_dat (head),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  // full comes from the registered level, so a pop cannot reopen in_ready in the same cycle.
  assign in_ready   = !reset && !full &&
                      (state_q == ST_RUN || state_q == ST_ISSUE || state_q == ST_GUARD);
  assign push       = bus.in_valid && in_ready;
  assign head_legal = (head < 4'd12);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    issued_cnt_d = issued_cnt_q;
    err_cnt_d    = err_cnt_q;
    seq_done_d   = seq_done_q;
    pop          = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!empty) begin
          if (!head_legal) begin
            pop = 1'b1;
            if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
          end else if (!bus.busy) begin
            pop         = 1'b1;
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            if (issued_cnt_q != 8'hFF) issued_cnt_d = issued_cnt_q + 8'd1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = (cmd_q == 4'd0) ? ST_WRITE_WAIT : ST_GUARD;
      end
      // Dead cycle so the controller has time to raise busy before we sample it again.
      ST_GUARD: begin
        state_d = ST_RUN;
      end
      ST_WRITE_WAIT: begin
        if (bus.done) begin
          seq_done_d = 1'b1;
          state_d    = ST_FINISHED;
        end
      end
      ST_FINISHED: begin
        state_d = ST_FINISHED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cmd_q        <= 4'd0;
      cmd_valid_q  <= 1'b0;
      issued_cnt_q <= 8'd0;
      err_cnt_q    <= 4'd0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      issued_cnt_q <= issued_cnt_d;
      err_cnt_q    <= err_cnt_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.fifo_level = level;
  assign bus.issued_cnt = issued_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.seq_done   = seq_done_q;
endmodule
